// File: rtl/pwm_deadtime_pkg.sv
// pwm_deadtime_pkg
//   Shared types and defaults for the dead-time insertion stage.
//   - DTW_DEFAULT : default width of the dead-time settings and counter
//   - dt_state_e  : gate-driver FSM state encoding
package pwm_deadtime_pkg;

  localparam int DTW_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LO_ON  = 3'd1,
    ST_DEAD_R = 3'd2,
    ST_HI_ON  = 3'd3,
    ST_DEAD_F = 3'd4,
    ST_FAULT  = 3'd5
  } dt_state_e;

endpackage

// File: rtl/pwm_dt_cnt.sv
// pwm_dt_cnt
//   Load / decrement / done down-counter used to time the dead band.
//   Ports:
//     clk_i      : clock
//     rst_i      : synchronous active-high reset (clears the count)
//     load_i     : load load_val_i this cycle (has priority over decrement)
//     load_val_i : value to load (effective dead time minus one)
//     dec_i      : decrement request; the count saturates at zero
//     done_o     : count is zero
module pwm_dt_cnt #(
  parameter int DTW = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic [DTW-1:0] load_val_i,
  input  logic           dec_i,
  output logic           done_o
);

  logic [DTW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DTW'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
//   Dead-time insertion between a raw PWM waveform and a complementary
//   high-side / low-side gate pair, with a sticky fault shutdown.
//   Ports:
//     clk_i       : clock shared with the PWM core
//     rst_i       : synchronous active-high reset
//     en_i        : stage enable; 0 parks both gates off
//     pwm_i       : raw PWM input
//     dt_rise_i   : dead time low-off -> high-on (cycles, 0 behaves as 1)
//     dt_fall_i   : dead time high-off -> low-on (cycles, 0 behaves as 1)
//     fault_i     : level fault request, forces both gates off
//     fault_clr_i : pulse that clears a latched fault once fault_i is low
//     pwm_hi_o    : high-side gate (registered)
//     pwm_lo_o    : low-side gate (registered)
//     fault_o     : latched fault status (registered)
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | disabled or just out of fault, both gates off
//   ST_LO_ON  | low-side gate on, following pwm_q = 0
//   ST_DEAD_R | both off, waiting dt_rise before high gate turns on
//   ST_HI_ON  | high-side gate on, following pwm_q = 1
//   ST_DEAD_F | both off, waiting dt_fall before low gate turns on
//   ST_FAULT  | fault latched, both gates off until cleared
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int DTW = DTW_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           pwm_i,
  input  logic [DTW-1:0] dt_rise_i,
  input  logic [DTW-1:0] dt_fall_i,
  input  logic           fault_i,
  input  logic           fault_clr_i,
  output logic           pwm_hi_o,
  output logic           pwm_lo_o,
  output logic           fault_o
);

  dt_state_e      state_q;
  dt_state_e      state_nxt;
  logic           pwm_q;
  logic           cnt_done;
  logic           cnt_load;
  logic           cnt_dec;
  logic [DTW-1:0] dt_sel;
  logic [DTW-1:0] load_val;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pwm_q    <= 1'b0;
      pwm_hi_o <= 1'b0;
      pwm_lo_o <= 1'b0;
      fault_o  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      pwm_q    <= pwm_i;
      pwm_hi_o <= (state_nxt == ST_HI_ON);
      pwm_lo_o <= (state_nxt == ST_LO_ON);
      fault_o  <= (state_nxt == ST_FAULT);
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (fault_i) begin
      state_nxt = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (fault_clr_i) begin
        state_nxt = ST_IDLE;
      end
    end else if (!en_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        // Both gates are already off here, so no dead band is needed.
        ST_IDLE:   state_nxt = pwm_q ? ST_HI_ON : ST_LO_ON;
        ST_LO_ON:  if (pwm_q) state_nxt = ST_DEAD_R;
        // A pulse shorter than the dead band is swallowed: fall back to
        // the gate that was on, the opposite gate never turned on.
        ST_DEAD_R: begin
          if (!pwm_q)        state_nxt = ST_LO_ON;
          else if (cnt_done) state_nxt = ST_HI_ON;
        end
        ST_HI_ON:  if (!pwm_q) state_nxt = ST_DEAD_F;
        ST_DEAD_F: begin
          if (pwm_q)         state_nxt = ST_HI_ON;
          else if (cnt_done) state_nxt = ST_LO_ON;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // The setting is captured only on entry to a dead band, so changes while
  // the counter runs apply from the next transition onward.
  assign cnt_load = ((state_q == ST_LO_ON) && (state_nxt == ST_DEAD_R)) ||
                    ((state_q == ST_HI_ON) && (state_nxt == ST_DEAD_F));
  assign cnt_dec  = (state_q == ST_DEAD_R) || (state_q == ST_DEAD_F);
  assign dt_sel   = (state_q == ST_LO_ON) ? dt_rise_i : dt_fall_i;
  // Load Deff-1 with Deff = max(dt,1); a zero setting still yields one
  // cycle with both gates off.
  assign load_val = (dt_sel == '0) ? '0 : (dt_sel - DTW'(1));

  pwm_dt_cnt #(
    .DTW(DTW)
  ) u_dt_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (load_val),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

endmodule

// File: tb/tb_pwm_deadtime.sv
module tb_pwm_deadtime;

  localparam int DTW = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           en_i;
  logic           pwm_i;
  logic [DTW-1:0] dt_rise_i;
  logic [DTW-1:0] dt_fall_i;
  logic           fault_i;
  logic           fault_clr_i;
  logic           pwm_hi_o;
  logic           pwm_lo_o;
  logic           fault_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic lo;
    logic hi;
    logic flt;
  } exp_t;

  exp_t sb[$];

  // Reference model: gate levels plus "cycles of dead band still owed".
  logic m_q, m_lo, m_hi, m_flt, m_run, m_tgt;
  int   m_dead;

  always #5 clk_i = ~clk_i;

  pwm_deadtime #(.DTW(DTW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .pwm_i       (pwm_i),
    .dt_rise_i   (dt_rise_i),
    .dt_fall_i   (dt_fall_i),
    .fault_i     (fault_i),
    .fault_clr_i (fault_clr_i),
    .pwm_hi_o    (pwm_hi_o),
    .pwm_lo_o    (pwm_lo_o),
    .fault_o     (fault_o)
  );

  function automatic int eff(input logic [DTW-1:0] dt);
    return (dt == '0) ? 1 : int'(dt);
  endfunction

  // Effect of one clock edge given the inputs currently applied.
  task automatic model_edge();
    if (rst_i) begin
      m_q = 0; m_lo = 0; m_hi = 0; m_flt = 0; m_run = 0; m_dead = 0;
    end else begin
      if (fault_i) begin
        m_flt = 1; m_run = 0; m_dead = 0; m_lo = 0; m_hi = 0;
      end else if (m_flt) begin
        if (fault_clr_i) m_flt = 0;
      end else if (!en_i) begin
        m_run = 0; m_dead = 0; m_lo = 0; m_hi = 0;
      end else if (!m_run) begin
        m_run = 1; m_hi = m_q; m_lo = !m_q;
      end else if (m_dead > 0) begin
        if (m_q != m_tgt) begin
          m_dead = 0; m_hi = !m_tgt; m_lo = m_tgt;
        end else begin
          m_dead--;
          if (m_dead == 0) begin
            m_hi = m_tgt; m_lo = !m_tgt;
          end
        end
      end else if (m_q != m_hi) begin
        m_tgt  = m_q;
        m_dead = eff(m_q ? dt_rise_i : dt_fall_i);
        m_lo   = 0;
        m_hi   = 0;
      end
      m_q = pwm_i;
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e.lo  = m_lo;
    e.hi  = m_hi;
    e.flt = m_flt;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  // sel: 0 wait for hi=1, 1 wait for lo=1, 2 wait for lo=0
  task automatic measure(input string name, input int sel, input int exp_n);
    int   n   = 0;
    logic hit = 1'b0;
    while (!hit && n < 64) begin
      step();
      n++;
      case (sel)
        0:       hit = pwm_hi_o;
        1:       hit = pwm_lo_o;
        default: hit = !pwm_lo_o;
      endcase
    end
    n_tests++;
    if (!hit || n != exp_n) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles (seen=%b), expected %0d", name, n, hit, exp_n);
    end
  endtask

  task automatic check_now(input string name, input logic [2:0] exp_v);
    n_tests++;
    if ({pwm_lo_o, pwm_hi_o, fault_o} !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got lo/hi/flt=%b, expected %b", name, {pwm_lo_o, pwm_hi_o, fault_o}, exp_v);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if ({pwm_lo_o, pwm_hi_o, fault_o} !== e) begin
        n_fail++;
        $display("FAIL gates @%0t: got lo=%b hi=%b flt=%b, expected lo=%b hi=%b flt=%b",
                 $time, pwm_lo_o, pwm_hi_o, fault_o, e.lo, e.hi, e.flt);
      end
      n_tests++;
      if (pwm_hi_o & pwm_lo_o) begin
        n_fail++;
        $display("FAIL overlap @%0t: got hi=%b lo=%b, expected not both 1", $time, pwm_hi_o, pwm_lo_o);
      end
    end
  end

  initial begin
    int run_left = 0;
    #2;
    rst_i = 1; en_i = 0; pwm_i = 0; dt_rise_i = '0; dt_fall_i = '0;
    fault_i = 0; fault_clr_i = 0;
    hold(3);
    check_now("reset", 3'b000);
    rst_i = 0;

    // Basic dead time
    en_i = 1; dt_rise_i = 8'd3; dt_fall_i = 8'd5;
    hold(6);
    pwm_i = 1; step();
    measure("lo_fall", 2, 1);
    measure("hi_rise", 0, 3);
    hold(5);
    pwm_i = 0; step();
    measure("lo_rise", 1, 6);
    hold(3);
    repeat (3) begin
      pwm_i = 1; hold(10);
      pwm_i = 0; hold(10);
    end

    // Zero dead time
    dt_rise_i = '0; dt_fall_i = '0;
    pwm_i = 1; step();
    measure("lo_fall_dt0", 2, 1);
    measure("hi_rise_dt0", 0, 1);
    hold(3);
    pwm_i = 0; step();
    measure("lo_rise_dt0", 1, 2);
    hold(3);
    repeat (4) begin
      pwm_i = 1; hold(4);
      pwm_i = 0; hold(4);
    end

    // Narrow pulse swallowed
    dt_rise_i = 8'd6; dt_fall_i = 8'd2;
    hold(8);
    pwm_i = 1; hold(3);
    pwm_i = 0; hold(10);

    // Fault handling
    pwm_i = 1; hold(12);
    check_now("hi_on_before_fault", 3'b010);
    fault_i = 1; step();
    check_now("fault_entry", 3'b001);
    fault_clr_i = 1; step();
    fault_clr_i = 0;
    check_now("clr_ignored", 3'b001);
    hold(2);
    fault_i = 0; hold(3);
    check_now("fault_sticky", 3'b001);
    fault_clr_i = 1; step();
    fault_clr_i = 0;
    check_now("fault_cleared", 3'b000);
    step();
    check_now("resume_hi", 3'b010);
    hold(4);

    // Enable drop mid DEAD_R, then reset mid DEAD_F
    dt_rise_i = 8'd5; dt_fall_i = 8'd5;
    pwm_i = 0; hold(10);
    pwm_i = 1; hold(3);
    en_i = 0; step();
    check_now("en_off", 3'b000);
    en_i = 1; step();
    check_now("reenable_hi", 3'b010);
    hold(4);
    pwm_i = 0; hold(3);
    rst_i = 1; step();
    check_now("reset_mid_deadf", 3'b000);
    rst_i = 0; hold(4);

    // Setting change during DEAD_R
    dt_rise_i = 8'd3; dt_fall_i = 8'd2;
    pwm_i = 0; hold(8);
    pwm_i = 1; step(); step();
    dt_rise_i = 8'd10;
    measure("hi_rise_old_dt", 0, 3);
    hold(5);
    pwm_i = 0; hold(10);
    pwm_i = 1; step(); step();
    measure("hi_rise_new_dt", 0, 10);
    hold(4);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        pwm_i    = ~pwm_i;
        run_left = int'($urandom_range(1, 12));
      end
      run_left--;
      if ($urandom_range(0, 31) == 0) dt_rise_i = DTW'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) dt_fall_i = DTW'($urandom_range(0, 7));
      if (fault_i) fault_i = ($urandom_range(0, 3) != 0);
      else         fault_i = ($urandom_range(0, 199) == 0);
      fault_clr_i = ($urandom_range(0, 9) == 0);
      if (en_i) en_i = ($urandom_range(0, 249) != 0);
      else      en_i = ($urandom_range(0, 7) == 0);
      rst_i = ($urandom_range(0, 799) == 0);
      step();
    end
    rst_i = 0; fault_i = 0; fault_clr_i = 0;

    @(negedge clk_i);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
# pwm_deadtime

Dead-time insertion stage directly downstream of the PWM peripheral. It consumes the raw PWM waveform and drives a complementary high-side/low-side gate pair. A programmable dead time is placed on every transition, so both switches are never on in the same cycle. A sticky fault input forces both gates off until software clears it.

## Interface
Parameters:
- `DTW`, default 8: width of the dead-time counters and settings, in cycles.

Ports:
- `clk_i`, in, 1: single clock, shared with the PWM core.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `en_i`, in, 1: stage enable. When 0, both gates are off.
- `pwm_i`, in, 1: raw PWM from the PWM core (`pwm_o` or `pwm_o_2`).
- `dt_rise_i`, in, `DTW`: cycles from the low gate turning off to the high gate turning on.
- `dt_fall_i`, in, `DTW`: cycles from the high gate turning off to the low gate turning on.
- `fault_i`, in, 1: synchronous fault request, level-sensitive.
- `fault_clr_i`, in, 1: single-cycle pulse that clears the latched fault.
- `pwm_hi_o`, out, 1: high-side gate, registered.
- `pwm_lo_o`, out, 1: low-side gate, registered.
- `fault_o`, out, 1: latched fault status, registered.

## Operation
- `pwm_i` is registered once into `pwm_q`. The FSM acts only on `pwm_q`.
- FSM states: IDLE, LO_ON, DEAD_R, HI_ON, DEAD_F, FAULT.
- Outputs are decoded from the next state and registered:
  - `pwm_lo_o` is 1 only in LO_ON.
  - `pwm_hi_o` is 1 only in HI_ON.
  - Both are 0 in every other state.
- Effective dead time is `Deff = max(dt, 1)`. A setting of 0 still gives one cycle with both gates off.
- The dead-time setting is sampled on entry to DEAD_R or DEAD_F. Changes made while the counter is running take effect at the next transition.

Transitions (priority top-down):
1. `fault_i` = 1 → FAULT, from any state. `fault_o` is set.
2. FAULT → IDLE when `fault_i` = 0 and `fault_clr_i` = 1. `fault_o` is cleared.
3. `en_i` = 0 → IDLE, from any non-FAULT state.
4. IDLE with `en_i` = 1 → LO_ON if `pwm_q` = 0, else HI_ON. No dead time is needed because both gates are already off.
5. LO_ON with `pwm_q` = 1 → DEAD_R.
6. DEAD_R:
   - If `pwm_q` = 0, go back to LO_ON. The pulse is narrower than the dead time and is swallowed; the high gate never turned on.
   - Otherwise go to HI_ON after `Deff` cycles.
7. HI_ON with `pwm_q` = 0 → DEAD_F.
8. DEAD_F:
   - If `pwm_q` = 1, go back to HI_ON.
   - Otherwise go to LO_ON after `Deff` cycles.

Invariants:
- `pwm_hi_o & pwm_lo_o` is never 1.
- Every transition of one gate from 1 to the opposite gate going to 1 has at least `Deff` cycles with both gates at 0. The only exception is the abort paths in steps 6 and 8, where the opposite gate never went high.

## Timing
- Reset values: state IDLE, `pwm_q` = 0, `pwm_hi_o` = 0, `pwm_lo_o` = 0, `fault_o` = 0, counter = 0.
- Reset mid-operation drops both gates at the next edge.
- Rising transition: `pwm_i` is first sampled at 1 at edge E.
  - `pwm_lo_o` falls at E+1.
  - `pwm_hi_o` rises at E+1+`Deff`.
- Falling transition: symmetric, using `dt_fall_i`.
- Throughput: the output waveform is the input delayed by 1 cycle, plus `Deff` on each leading gate edge. The sustained rate is one transition per cycle pair.
- Fault latency: `fault_i` = 1 at edge E gives both gates 0 and `fault_o` = 1 at E+1.
- Simultaneous `fault_i` and `fault_clr_i`: the fault wins and `fault_o` stays 1.
- `fault_clr_i` while `fault_i` = 1 is ignored.
- `en_i` falling at edge E gives both gates 0 at E+1.
- Counter arithmetic:
  - The counter loads `Deff`−1 and decrements to 0.
  - Width is `DTW`; it does not wrap.
  - Maximum dead time is 2^`DTW`−1 cycles.

## Structure
- Package `pwm_deadtime_pkg`:
  - FSM state enum `dt_state_e`.
  - `DTW` default constant.
- Sub-module `pwm_dt_cnt`: load / decrement / done counter of width `DTW`, instantiated once and shared by DEAD_R and DEAD_F.
- Top-level placement: one instance per PWM output, each fed from `pwm_o` or `pwm_o_2`.

## Test plan
- **Basic dead time:** `DTW`=8, `dt_rise`=3, `dt_fall`=5, `en`=1, `pwm_i` square wave with 20-cycle period → `lo` falls 1 cycle after `pwm_i` rises; `hi` rises 4 cycles after `pwm_i` rises; `lo` rises 6 cycles after `pwm_i` falls; `hi & lo` is never 1.
- **Zero dead time:** `dt_rise`=0, `dt_fall`=0 → exactly 1 cycle with both gates 0 on every transition.
- **Narrow pulse:** `dt_rise`=6, `pwm_i` high for 3 cycles → `hi` never asserts; `lo` is off for 3 cycles then back on.
- **Fault:** fault mid-HI_ON → both gates 0 next cycle and `fault_o`=1. `fault_clr` while `fault_i`=1 → no effect. Release `fault_i`, then pulse `fault_clr` → IDLE, then the gates resume per `pwm_i`.
- **Enable and reset mid-dead-time:** `en_i`=0 during DEAD_R → both gates 0 next cycle; re-enable with `pwm_i`=1 → `hi` at 1 cycle. Reset asserted mid-DEAD_F → all outputs 0 at the next edge.
- **Setting change:** change `dt_rise` from 3 to 10 during DEAD_R → the current dead time stays 3, and the next rising transition uses 10.
